// File: rtl/dekatron_pkg.sv
// dekatron_pkg: shared state encoding and BCD sizing for dekatron counter control.
package dekatron_pkg;
    localparam int DIG_W = 4;
    typedef enum logic [2:0] {IDLE, CHECK, REQ, LOAD, WAIT_LO, WAIT_HI, FIN} state_e;
    function automatic int bcd_w(input int d_num);
        return d_num * DIG_W;
    endfunction
endpackage

// File: rtl/bcd_mag_cmp.sv
// bcd_mag_cmp: equality and magnitude compare of two BCD vectors.
// The lt path exists only when LT_EN is set.
module bcd_mag_cmp
    import dekatron_pkg::*;
#(
    parameter int D_NUM = 6,
    parameter bit LT_EN = 1'b1
) (
    input  logic [bcd_w(D_NUM)-1:0] a,
    input  logic [bcd_w(D_NUM)-1:0] b,
    output logic                    eq,
    output logic                    lt
);
    assign eq = a == b;
    if (LT_EN) begin : g_lt
        // valid BCD digits order exactly like binary, MSD first
        assign lt = a < b;
    end else begin : g_no_lt
        assign lt = 1'b0;
    end
endmodule

// File: rtl/counter_seek_ctrl.sv
// counter_seek_ctrl: drives a dekatron Counter to a BCD target by stepping or Set-load.
// Define SEEK_SHORTEST_EN to pick the decrement direction when the target is below the count.
module counter_seek_ctrl
    import dekatron_pkg::*;
#(
    parameter int D_NUM  = 6,
    parameter int STEP_W = 24
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Start,
    input  logic                    Load,
    input  logic                    Abort,
    input  logic [bcd_w(D_NUM)-1:0] Target,
    output logic                    Busy,
    output logic                    Done,
    output logic [STEP_W-1:0]       Steps,
    output logic                    CntRequest,
    output logic                    CntDec,
    output logic                    CntSet,
    output logic [bcd_w(D_NUM)-1:0] CntIn,
    input  logic                    CntReady,
    input  logic [bcd_w(D_NUM)-1:0] CntOut
);
    localparam int W = bcd_w(D_NUM);
`ifdef SEEK_SHORTEST_EN
    localparam bit SHORT = 1'b1;
`else
    localparam bit SHORT = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [W-1:0]      tgt_q, tgt_d, cin_q, cin_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              load_q, load_d, abort_q, abort_d, dec_q, dec_d;
    logic              req_q, req_d, set_q, set_d;
    logic              eq, lt;

    bcd_mag_cmp #(.D_NUM(D_NUM), .LT_EN(SHORT)) u_cmp (
        .a  (tgt_q),
        .b  (CntOut),
        .eq (eq),
        .lt (lt)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        load_d  = load_q;
        abort_d = abort_q | (Abort && state_q != IDLE);
        steps_d = steps_q;
        dec_d   = dec_q;
        cin_d   = cin_q;
        req_d   = 1'b0;
        set_d   = 1'b0;
        case (state_q)
            IDLE: if (Start) begin
                tgt_d   = Target;
                load_d  = Load;
                abort_d = 1'b0;
                steps_d = '0;
                cin_d   = Load ? Target : '0;
                state_d = Load ? LOAD : CHECK;
            end
            CHECK: if (eq || abort_d) begin
                state_d = FIN;
            end else begin
                dec_d   = lt;
                state_d = REQ;
            end
            REQ: if (CntReady) begin
                req_d   = 1'b1;
                steps_d = &steps_q ? steps_q : steps_q + 1'b1;
                state_d = WAIT_LO;
            end
            // an abort here wins over a Set that would issue this cycle
            LOAD: if (abort_d) begin
                state_d = FIN;
            end else if (CntReady) begin
                set_d   = 1'b1;
                state_d = WAIT_LO;
            end
            WAIT_LO: state_d = CntReady ? WAIT_LO : WAIT_HI;
            WAIT_HI: state_d = !CntReady ? WAIT_HI : load_q ? FIN : CHECK;
            FIN: begin
                cin_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            load_q  <= 1'b0;
            abort_q <= 1'b0;
            steps_q <= '0;
            dec_q   <= 1'b0;
            cin_q   <= '0;
            req_q   <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            load_q  <= load_d;
            abort_q <= abort_d;
            steps_q <= steps_d;
            dec_q   <= dec_d;
            cin_q   <= cin_d;
            req_q   <= req_d;
            set_q   <= set_d;
        end
    end

    assign Busy       = state_q != IDLE;
    assign Done       = state_q == FIN;
    assign Steps      = steps_q;
    assign CntRequest = req_q;
    assign CntDec     = dec_q;
    assign CntSet     = set_q;
    assign CntIn      = cin_q;
endmodule

// File: tb/tb_counter_seek_ctrl.sv
// tb_counter_seek_ctrl: directed checks of counter_seek_ctrl against a behavioural 2-digit Counter.
module tb_counter_seek_ctrl;
    logic        Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, Load = 1'b0, Abort = 1'b0;
    logic [7:0]  Target = '0, CntIn, CntOut;
    logic        Busy, Done, CntRequest, CntDec, CntSet, CntReady;
    logic [23:0] Steps;

    counter_seek_ctrl #(.D_NUM(2), .STEP_W(24)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Load(Load), .Abort(Abort), .Target(Target),
        .Busy(Busy), .Done(Done), .Steps(Steps), .CntRequest(CntRequest), .CntDec(CntDec),
        .CntSet(CntSet), .CntIn(CntIn), .CntReady(CntReady), .CntOut(CntOut)
    );

    always #5 Clk = ~Clk;

    // Counter model: Ready drops the cycle after Request/Set and returns 3 cycles later
    logic [7:0] cnt = 8'h00, pre_val = 8'h00;
    logic       rdy = 1'b1, pre_req = 1'b0;
    int         cd = 0;
    assign CntOut   = cnt;
    assign CntReady = rdy;

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic dn);
        int b;
        b = int'(v[7:4]) * 10 + int'(v[3:0]);
        b = dn ? (b + 99) % 100 : (b + 1) % 100;
        return {4'(b / 10), 4'(b % 10)};
    endfunction

    always @(posedge Clk) begin
        if (pre_req) cnt <= pre_val;
        else if (CntRequest) begin cnt <= bcd_step(cnt, CntDec); rdy <= 1'b0; cd <= 3; end
        else if (CntSet) begin cnt <= CntIn; rdy <= 1'b0; cd <= 3; end
        else if (cd > 0) begin cd <= cd - 1; if (cd == 1) rdy <= 1'b1; end
    end

    int req_n = 0, dec_n = 0, set_n = 0, done_n = 0, proto_n = 0;
    logic [7:0] set_in = '0;
    always @(negedge Clk) begin
        if (CntRequest) begin req_n++; if (CntDec) dec_n++; end
        if (CntSet) begin set_n++; set_in = CntIn; end
        if (Done) done_n++;
        if ((CntRequest || CntSet) && !CntReady) proto_n++;
        if (CntRequest && CntSet) proto_n++;
    end

    int n_cmp = 0, n_bad = 0;
    int b_req, b_dec, b_set, b_done, lat;
    bit ok;
    logic busy_at_done, busy_after, done_after;

    task automatic preset(input logic [7:0] v);
        @(negedge Clk); pre_req = 1'b1; pre_val = v;
        @(negedge Clk); pre_req = 1'b0;
    endtask

    task automatic snap();
        b_req = req_n; b_dec = dec_n; b_set = set_n; b_done = done_n;
    endtask

    task automatic wait_done();
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge Clk); Start = 1'b0; lat++;
            if (Done) ok = 1'b1;
        end
        busy_at_done = Busy;
        @(negedge Clk); busy_after = Busy; done_after = Done;
        @(negedge Clk);
    endtask

    task automatic run_cmd(input logic ld, input logic [7:0] tgt);
        snap();
        @(negedge Clk); Start = 1'b1; Load = ld; Target = tgt;
        wait_done();
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", Done); end
        n_cmp++; if (Steps !== 24'd0) begin n_bad++; $display("FAIL rst_steps got %0d want 0", Steps); end
        n_cmp++; if ({CntRequest, CntSet, CntDec} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl got %b want 000", {CntRequest, CntSet, CntDec}); end
        n_cmp++; if (CntIn !== 8'h00) begin n_bad++; $display("FAIL rst_cntin got %h want 00", CntIn); end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_step_up();
        run_cmd(1'b0, 8'h05);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL up_timeout got no Done want Done"); end
        n_cmp++; if (req_n - b_req != 5) begin n_bad++; $display("FAIL up_reqs got %0d want 5", req_n - b_req); end
        n_cmp++; if (dec_n - b_dec != 0) begin n_bad++; $display("FAIL up_decs got %0d want 0", dec_n - b_dec); end
        n_cmp++; if (cnt !== 8'h05) begin n_bad++; $display("FAIL up_cnt got %h want 05", cnt); end
        n_cmp++; if (Steps !== 24'd5) begin n_bad++; $display("FAIL up_steps got %0d want 5", Steps); end
        n_cmp++; if (done_n - b_done != 1) begin n_bad++; $display("FAIL up_done_pulses got %0d want 1", done_n - b_done); end
        n_cmp++; if (busy_at_done !== 1'b1) begin n_bad++; $display("FAIL up_busy_fin got %b want 1", busy_at_done); end
        n_cmp++; if ({busy_after, done_after} !== 2'b00) begin n_bad++; $display("FAIL up_idle got %b want 00", {busy_after, done_after}); end
    endtask

    task automatic test_wrap();
        preset(8'h07);
        run_cmd(1'b0, 8'h03);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout got no Done want Done"); end
        n_cmp++; if (cnt !== 8'h03) begin n_bad++; $display("FAIL wrap_cnt got %h want 03", cnt); end
`ifdef SEEK_SHORTEST_EN
        n_cmp++; if (req_n - b_req != 4) begin n_bad++; $display("FAIL wrap_reqs got %0d want 4", req_n - b_req); end
        n_cmp++; if (dec_n - b_dec != 4) begin n_bad++; $display("FAIL wrap_decs got %0d want 4", dec_n - b_dec); end
        n_cmp++; if (Steps !== 24'd4) begin n_bad++; $display("FAIL wrap_steps got %0d want 4", Steps); end
        n_cmp++; if (CntDec !== 1'b1) begin n_bad++; $display("FAIL wrap_dir got %b want 1", CntDec); end
`else
        n_cmp++; if (req_n - b_req != 96) begin n_bad++; $display("FAIL wrap_reqs got %0d want 96", req_n - b_req); end
        n_cmp++; if (dec_n - b_dec != 0) begin n_bad++; $display("FAIL wrap_decs got %0d want 0", dec_n - b_dec); end
        n_cmp++; if (Steps !== 24'd96) begin n_bad++; $display("FAIL wrap_steps got %0d want 96", Steps); end
        n_cmp++; if (CntDec !== 1'b0) begin n_bad++; $display("FAIL wrap_dir got %b want 0", CntDec); end
`endif
    endtask

    task automatic test_load();
        run_cmd(1'b1, 8'h39);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL load_timeout got no Done want Done"); end
        n_cmp++; if (set_n - b_set != 1) begin n_bad++; $display("FAIL load_sets got %0d want 1", set_n - b_set); end
        n_cmp++; if (set_in !== 8'h39) begin n_bad++; $display("FAIL load_cntin got %h want 39", set_in); end
        n_cmp++; if (req_n - b_req != 0) begin n_bad++; $display("FAIL load_reqs got %0d want 0", req_n - b_req); end
        n_cmp++; if (cnt !== 8'h39) begin n_bad++; $display("FAIL load_cnt got %h want 39", cnt); end
        n_cmp++; if (Steps !== 24'd0) begin n_bad++; $display("FAIL load_steps got %0d want 0", Steps); end
        n_cmp++; if (done_n - b_done != 1) begin n_bad++; $display("FAIL load_done_pulses got %0d want 1", done_n - b_done); end
        n_cmp++; if (CntIn !== 8'h00) begin n_bad++; $display("FAIL load_cntin_idle got %h want 00", CntIn); end
    endtask

    task automatic test_zero_step();
        preset(8'h12);
        run_cmd(1'b0, 8'h12);
        n_cmp++; if (!ok || lat != 2) begin n_bad++; $display("FAIL zero_latency got %0d want 2", lat); end
        n_cmp++; if (Steps !== 24'd0) begin n_bad++; $display("FAIL zero_steps got %0d want 0", Steps); end
        n_cmp++; if (req_n - b_req != 0) begin n_bad++; $display("FAIL zero_reqs got %0d want 0", req_n - b_req); end
        n_cmp++; if (cnt !== 8'h12) begin n_bad++; $display("FAIL zero_cnt got %h want 12", cnt); end
    endtask

    task automatic test_abort();
        preset(8'h00);
        snap();
        @(negedge Clk); Start = 1'b1; Load = 1'b0; Target = 8'h10;
        @(negedge Clk); Start = 1'b0;
        for (int i = 0; i < 2000 && !(req_n - b_req == 3 && !CntReady); i++) @(negedge Clk);
        n_cmp++; if (!(req_n - b_req == 3 && !CntReady)) begin n_bad++; $display("FAIL abort_reach got %0d reqs want 3", req_n - b_req); end
        @(negedge Clk); Abort = 1'b1;
        @(negedge Clk); Abort = 1'b0;
        wait_done();
        repeat (10) @(negedge Clk);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_timeout got no Done want Done"); end
        n_cmp++; if (req_n - b_req != 3) begin n_bad++; $display("FAIL abort_reqs got %0d want 3", req_n - b_req); end
        n_cmp++; if (cnt !== 8'h03) begin n_bad++; $display("FAIL abort_cnt got %h want 03", cnt); end
        n_cmp++; if (Steps !== 24'd3) begin n_bad++; $display("FAIL abort_steps got %0d want 3", Steps); end
        n_cmp++; if (done_n - b_done != 1) begin n_bad++; $display("FAIL abort_done_pulses got %0d want 1", done_n - b_done); end
    endtask

    task automatic test_reset_mid();
        preset(8'h20);
        snap();
        @(negedge Clk); Start = 1'b1; Load = 1'b0; Target = 8'h25;
        @(negedge Clk); Start = 1'b0;
        for (int i = 0; i < 2000 && !(req_n - b_req == 1 && !CntReady); i++) @(negedge Clk);
        n_cmp++; if (!(req_n - b_req == 1 && !CntReady)) begin n_bad++; $display("FAIL mid_reach got %0d reqs want 1", req_n - b_req); end
        Rst_n = 1'b0;
        @(negedge Clk); Rst_n = 1'b1;
        n_cmp++; if ({Busy, Done, CntRequest, CntSet, CntDec} !== 5'b0) begin n_bad++; $display("FAIL mid_ctl got %b want 00000", {Busy, Done, CntRequest, CntSet, CntDec}); end
        n_cmp++; if (Steps !== 24'd0) begin n_bad++; $display("FAIL mid_steps got %0d want 0", Steps); end
        n_cmp++; if (CntIn !== 8'h00) begin n_bad++; $display("FAIL mid_cntin got %h want 00", CntIn); end
        n_cmp++; if (cnt !== 8'h21) begin n_bad++; $display("FAIL mid_cnt got %h want 21", cnt); end
        run_cmd(1'b0, 8'h25);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_timeout got no Done want Done"); end
        n_cmp++; if (cnt !== 8'h25) begin n_bad++; $display("FAIL mid_cnt_end got %h want 25", cnt); end
        n_cmp++; if (Steps !== 24'd4) begin n_bad++; $display("FAIL mid_steps_end got %0d want 4", Steps); end
        n_cmp++; if (proto_n != 0) begin n_bad++; $display("FAIL protocol got %0d violations want 0", proto_n); end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_wrap();
        test_load();
        test_zero_step();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/counter_seek_ctrl.md
Name: counter_seek_ctrl

Overview:
- Initiator for the dekatron Counter Request/Ready interface: drives Request, Dec, Set and In, and watches Ready and Out.
- Accepts a seek command from the sequencer: either step the counter one count at a time until Out equals Target, or load Target in a single Set transaction.
- Sits between the machine sequencer and one Counter instance (e.g. IP or AP register).

Parameters:
D_NUM, 6, number of BCD digits in Target/CntIn/CntOut
STEP_W, 24, width of the step-count output (binary, saturating)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  reset; synchronous, active-low
Start  in  1  command strobe, sampled only in IDLE
Load  in  1  with Start: 1 = Set-load Target, 0 = step-seek to Target
Abort  in  1  stop seek after the in-flight transaction completes
Target  in  D_NUM*4  BCD target value, latched on accepted Start
Busy  out  1  command in progress
Done  out  1  one-cycle pulse when the command completes or is aborted
Steps  out  STEP_W  step transactions issued by the last command
CntRequest  out  1  to Counter Request, one-cycle pulse
CntDec  out  1  to Counter Dec: 1 = decrement, 0 = increment
CntSet  out  1  to Counter Set
CntIn  out  D_NUM*4  to Counter In
CntReady  in  1  from Counter Ready
CntOut  in  D_NUM*4  from Counter Out, BCD

Behaviour:
- Reset (Rst_n=0 at a rising edge): state IDLE; Busy=0, Done=0, Steps=0, CntRequest=0, CntDec=0, CntSet=0, CntIn=0; latched target=0. Reset mid-transaction abandons it without waiting for Ready.
- Protocol rules:
  - A transaction starts with exactly one cycle of CntRequest=1 (CntSet=0) or CntSet=1 (CntRequest=0).
  - It is issued only in a cycle where CntReady=1.
  - The transaction is complete when CntReady has been seen 0 and then 1 again. The number of wait cycles is unbounded.
  - CntDec and CntIn are held stable from issue until completion.
- States:
  - IDLE: Busy=0. On Start=1, latch Target and Load, clear Steps, go to CHECK (Load=0) or LOAD (Load=1). Start in any other state is ignored.
  - CHECK: if CntOut == latched target, or an abort is pending, go to FIN. Otherwise set CntDec per the direction rule and go to REQ.
  - REQ: wait for CntReady=1, then pulse CntRequest for one cycle, increment Steps (saturates at all-ones), go to WAIT_LO.
  - LOAD: drive CntIn=target; wait for CntReady=1, then pulse CntSet for one cycle, go to WAIT_LO.
  - WAIT_LO: stay until CntReady=0, then go to WAIT_HI.
  - WAIT_HI: stay until CntReady=1, then go to CHECK (step mode) or FIN (load mode).
  - FIN: Done=1 for one cycle, Busy=0 next cycle, CntIn=0, go to IDLE.
- Busy=1 in every state except IDLE.
- Direction (default): always increment (CntDec=0). A seek may wrap through 10^D_NUM-1 -> 0.
- Abort:
  - Sets a sticky pending flag while Busy.
  - The in-flight transaction always completes; FIN is taken at the next CHECK.
  - Abort in LOAD before the Set is issued goes straight to FIN.
  - Abort in IDLE is ignored.
- Zero-step case: Start with Target == CntOut (step mode) gives Done two cycles after Start, with Steps=0 and no Request issued.
- Latency per step: 3 cycles plus the Counter's wait time.

Optional Feature:
- Macro SEEK_SHORTEST_EN.
- Defined: in CHECK, CntDec=1 if target < CntOut by BCD magnitude compare (digit-wise from the MSD), else CntDec=0. No wrap is ever used, so the step count equals |target - CntOut|.
- Undefined: always increment as described above; the comparator logic is not synthesised.

Decomposition:
- Shared package dekatron_pkg:
  - state enum (IDLE, CHECK, REQ, LOAD, WAIT_LO, WAIT_HI, FIN)
  - BCD digit width constant 4
  - a function computing the BCD vector width from D_NUM
- One natural sub-module, bcd_mag_cmp: parameter D_NUM; inputs a, b; outputs eq, lt. Its eq output is used in both builds; lt is used only under SEEK_SHORTEST_EN.

Test Plan:
(Bench uses a behavioural Counter model: Ready falls 1 cycle after Request/Set and rises COUNT_DELAY=3 cycles later.)
- Counter=0, Start Load=0 Target=5 -> 5 increment Requests, CntDec=0, CntOut=5, Steps=5, single Done pulse.
- Counter=7, Target=3, macro off -> wraps through 999999, Steps=999996 (shorten with D_NUM=2: 96 steps, CntOut=03). Macro on -> 4 decrements, CntDec=1, Steps=4.
- Start Load=1 Target=39 -> exactly one CntSet pulse with CntIn=39, zero CntRequest pulses, CntOut=39, Done, Steps=0.
- Target == CntOut=12 -> no Request; Done two cycles after Start; Steps=0.
- Abort asserted during WAIT_HI of the 3rd step toward Target=10 -> that step completes, Done pulses, CntOut=3, Steps=3, no further Request.
- Rst_n=0 for 1 cycle while in WAIT_LO -> all outputs at reset values next cycle; a new Start afterwards works normally; no Request is issued while CntReady=0.
